// File: rtl/pc_mt_pkg.sv
// Shared constants and helpers for the multi-thread fetch program counter.
package pc_mt_pkg;

  localparam int unsigned IAlign4 = 4;
  localparam int unsigned IAlign2 = 2;

  localparam logic [31:0] DefResetPc = 32'h0000_0000;

  // Thread id width never collapses to zero bits, even for a single thread.
  function automatic int unsigned tid_width(input int unsigned nthreads);
    return (nthreads <= 2) ? 1 : $clog2(nthreads);
  endfunction

endpackage

// File: rtl/pc_mt_if.sv
// Control/status bundle between the fetch-stage PC and its pipeline neighbours.
interface pc_mt_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TIDW = 1
);

  logic            HLT;
  logic            JREQ;
  logic [XLEN-1:0] JVAL;
  logic            TREQ;
  logic [XLEN-1:0] TVEC;
  logic            ILEN2;
  logic            TSW;
  logic [XLEN-1:0] PCO;
  logic [XLEN-1:0] NXPCO;
  logic [TIDW-1:0] TIDO;
  logic [XLEN-1:0] EPCO;
  logic [TIDW-1:0] ETIDO;
  logic            MISALIGN;

  modport master (
    output HLT, JREQ, JVAL, TREQ, TVEC, ILEN2, TSW,
    input  PCO, NXPCO, TIDO, EPCO, ETIDO, MISALIGN
  );

  modport slave (
    input  HLT, JREQ, JVAL, TREQ, TVEC, ILEN2, TSW,
    output PCO, NXPCO, TIDO, EPCO, ETIDO, MISALIGN
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next fetch address selection for the active thread: trap, jump or sequential.
module pc_next_sel
  import pc_mt_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 4
) (
  input  logic [XLEN-1:0] cur_nxpc,
  input  logic [2:0]      inc,
  input  logic            jreq,
  input  logic [XLEN-1:0] jval,
  input  logic            treq,
  input  logic [XLEN-1:0] tvec,
  output logic [XLEN-1:0] next,
  output logic            mis
);

  always_comb begin
    mis  = jreq && (IALIGN == IAlign4) && jval[1];
    next = cur_nxpc + XLEN'(inc);
    // A misaligned jump is redirected exactly like a trap.
    if (treq || mis) begin
      next = tvec;
    end else if (jreq) begin
      next = {jval[XLEN-1:1], 1'b0};
    end
  end

endmodule

// File: rtl/pc_mt.sv
// Multi-thread program counter: per-thread next-PC, shared PC, trap capture.
module pc_mt
  import pc_mt_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESETPC     = XLEN'(DefResetPc),
  parameter logic [XLEN-1:0] RESETSTRIDE = '0,
  parameter int unsigned     NTHREADS    = 2,
  parameter int unsigned     IALIGN      = 4
) (
  input logic    CLK,
  input logic    XRESN,
  pc_mt_if.slave bus
);

  localparam int unsigned TIDW  = tid_width(NTHREADS);
  localparam int unsigned NSLOT = 1 << TIDW;

  logic [XLEN-1:0] nxpc_q [NSLOT];
  logic [XLEN-1:0] pc_q, epc_q;
  logic [TIDW-1:0] tid_q, tid_d, etid_q;
  logic            mis_q;

  logic [XLEN-1:0] cur_nxpc, next_nxpc;
  logic [2:0]      inc;
  logic            mis, trap;

  assign cur_nxpc = nxpc_q[tid_q];
  assign inc      = ((IALIGN == IAlign2) && bus.ILEN2) ? 3'd2 : 3'd4;
  assign trap     = bus.TREQ || mis;

  pc_next_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_sel (
    .cur_nxpc (cur_nxpc),
    .inc      (inc),
    .jreq     (bus.JREQ),
    .jval     (bus.JVAL),
    .treq     (bus.TREQ),
    .tvec     (bus.TVEC),
    .next     (next_nxpc),
    .mis      (mis)
  );

  always_comb begin
    tid_d = tid_q;
    if ((NTHREADS > 1) && bus.TSW) begin
      tid_d = (tid_q == TIDW'(NTHREADS - 1)) ? '0 : tid_q + TIDW'(1);
    end
  end

  always_ff @(posedge CLK or negedge XRESN) begin
    if (!XRESN) begin
      for (int t = 0; t < NSLOT; t++) begin
        nxpc_q[t] <= RESETPC + XLEN'(t) * RESETSTRIDE;
      end
      pc_q   <= RESETPC;
      tid_q  <= '0;
      epc_q  <= '0;
      etid_q <= '0;
      mis_q  <= 1'b0;
    end else if (!bus.HLT) begin
      // The update targets the thread active this cycle, even when switching away.
      nxpc_q[tid_q] <= next_nxpc;
      pc_q          <= cur_nxpc;
      if (trap) begin
        epc_q  <= pc_q;
        etid_q <= tid_q;
      end
      mis_q <= mis && !bus.TREQ;
      tid_q <= tid_d;
    end
  end

  assign bus.NXPCO    = cur_nxpc;
  assign bus.TIDO     = tid_q;
  assign bus.PCO      = pc_q;
  assign bus.EPCO     = epc_q;
  assign bus.ETIDO    = etid_q;
  assign bus.MISALIGN = mis_q;

endmodule

// File: tb/tb_pc_mt.sv
// Scoreboard bench: three pc_mt configurations share stimulus; a reference model predicts outputs.
module tb_pc_mt;

  typedef struct packed {
    logic        hlt;
    logic        jreq;
    logic        treq;
    logic        tsw;
    logic        ilen2;
    logic [31:0] jval;
    logic [31:0] tvec;
  } stim_t;

  typedef struct packed {
    logic [3:0][31:0] nx;
    logic [31:0]      pc;
    logic [31:0]      epc;
    logic [1:0]       tid;
    logic [1:0]       etid;
    logic             mis;
  } mstate_t;

  typedef struct packed {
    logic [31:0] nxpco;
    logic [31:0] pco;
    logic [31:0] epco;
    logic [1:0]  tido;
    logic [1:0]  etido;
    logic        mis;
  } obs_t;

  localparam logic [31:0] RPC [3] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFC};
  localparam logic [31:0] STR [3] = '{32'h0, 32'h1000, 32'h10};
  localparam int          NTH [3] = '{1, 2, 4};
  localparam int          IAL [3] = '{4, 4, 2};

  logic CLK = 1'b0;
  logic XRESN;
  always #5 CLK = ~CLK;

  pc_mt_if #(.XLEN(32), .TIDW(1)) if0 ();
  pc_mt_if #(.XLEN(32), .TIDW(1)) if1 ();
  pc_mt_if #(.XLEN(32), .TIDW(2)) if2 ();

  pc_mt #(.XLEN(32), .RESETPC(RPC[0]), .RESETSTRIDE(STR[0]), .NTHREADS(1), .IALIGN(4))
    u_dut0 (.CLK(CLK), .XRESN(XRESN), .bus(if0));
  pc_mt #(.XLEN(32), .RESETPC(RPC[1]), .RESETSTRIDE(STR[1]), .NTHREADS(2), .IALIGN(4))
    u_dut1 (.CLK(CLK), .XRESN(XRESN), .bus(if1));
  pc_mt #(.XLEN(32), .RESETPC(RPC[2]), .RESETSTRIDE(STR[2]), .NTHREADS(4), .IALIGN(2))
    u_dut2 (.CLK(CLK), .XRESN(XRESN), .bus(if2));

  int      errors = 0;
  int      checks = 0;
  obs_t    exp_q[$];
  mstate_t ms[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_obs(input int i, input string tag, input obs_t a, input obs_t e);
    chk($sformatf("%s u%0d NXPCO", tag, i), a.nxpco, e.nxpco);
    chk($sformatf("%s u%0d PCO", tag, i), a.pco, e.pco);
    chk($sformatf("%s u%0d EPCO", tag, i), a.epco, e.epco);
    chk($sformatf("%s u%0d TIDO", tag, i), 32'(a.tido), 32'(e.tido));
    chk($sformatf("%s u%0d ETIDO", tag, i), 32'(a.etido), 32'(e.etido));
    chk($sformatf("%s u%0d MISALIGN", tag, i), 32'(a.mis), 32'(e.mis));
  endtask

  function automatic obs_t sample(input int i);
    obs_t o;
    case (i)
      0: o = '{if0.NXPCO, if0.PCO, if0.EPCO, {1'b0, if0.TIDO}, {1'b0, if0.ETIDO}, if0.MISALIGN};
      1: o = '{if1.NXPCO, if1.PCO, if1.EPCO, {1'b0, if1.TIDO}, {1'b0, if1.ETIDO}, if1.MISALIGN};
      default: o = '{if2.NXPCO, if2.PCO, if2.EPCO, if2.TIDO, if2.ETIDO, if2.MISALIGN};
    endcase
    return o;
  endfunction

  // Reference model: one next-PC per thread, threads rotate round-robin.
  function automatic mstate_t mreset(input int i);
    mstate_t s = '0;
    for (int t = 0; t < NTH[i]; t++) s.nx[t] = RPC[i] + 32'(t) * STR[i];
    s.pc = RPC[i];
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int i, input stim_t in);
    mstate_t n = s;
    logic [31:0] cur = s.nx[s.tid];
    int   step;
    logic misal;
    if (in.hlt) return s;
    step  = (IAL[i] == 2 && in.ilen2) ? 2 : 4;
    misal = in.jreq && IAL[i] == 4 && in.jval[1];
    if (in.treq || misal) begin
      n.nx[s.tid] = in.tvec;
      n.epc       = s.pc;
      n.etid      = s.tid;
    end else if (in.jreq) begin
      n.nx[s.tid] = in.jval & 32'hFFFF_FFFE;
    end else begin
      n.nx[s.tid] = cur + 32'(step);
    end
    n.pc  = cur;
    n.mis = misal && !in.treq;
    if (in.tsw) n.tid = 2'((int'(s.tid) + 1) % NTH[i]);
    return n;
  endfunction

  function automatic obs_t mobs(input mstate_t s);
    return '{s.nx[s.tid], s.pc, s.epc, s.tid, s.etid, s.mis};
  endfunction

  task automatic drive(input stim_t s);
    if0.HLT = s.hlt; if0.JREQ = s.jreq; if0.TREQ = s.treq; if0.TSW = s.tsw;
    if0.ILEN2 = s.ilen2; if0.JVAL = s.jval; if0.TVEC = s.tvec;
    if1.HLT = s.hlt; if1.JREQ = s.jreq; if1.TREQ = s.treq; if1.TSW = s.tsw;
    if1.ILEN2 = s.ilen2; if1.JVAL = s.jval; if1.TVEC = s.tvec;
    if2.HLT = s.hlt; if2.JREQ = s.jreq; if2.TREQ = s.treq; if2.TSW = s.tsw;
    if2.ILEN2 = s.ilen2; if2.JVAL = s.jval; if2.TVEC = s.tvec;
  endtask

  function automatic stim_t mk(input logic hlt, input logic jreq, input logic treq,
                               input logic tsw, input logic ilen2,
                               input logic [31:0] jval, input logic [31:0] tvec);
    return '{hlt, jreq, treq, tsw, ilen2, jval, tvec};
  endfunction

  // Called at negedge+1; the entries pushed here are checked at the next negedge.
  task automatic do_step(input stim_t s);
    drive(s);
    for (int i = 0; i < 3; i++) begin
      ms[i] = mstep(ms[i], i, s);
      exp_q.push_back(mobs(ms[i]));
    end
    @(negedge CLK);
    #1;
  endtask

  // Reset lands between edges; outputs must already be at reset values before the next edge.
  task automatic async_reset(input string tag);
    #1 XRESN = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      ms[i] = mreset(i);
      chk_obs(i, tag, sample(i), mobs(ms[i]));
      exp_q.push_back(mobs(ms[i]));
    end
    @(negedge CLK);
    #1 XRESN = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        obs_t e;
        e = exp_q.pop_front();
        chk_obs(i, "sb", sample(i), e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle;
    stim_t s;
    idle  = mk(0, 0, 0, 0, 0, 32'h0, 32'h0);
    XRESN = 1'b0;
    drive(idle);
    #2;
    for (int i = 0; i < 3; i++) begin
      ms[i] = mreset(i);
      exp_q.push_back(mobs(ms[i]));
    end
    @(negedge CLK);
    #1 XRESN = 1'b1;

    repeat (3) do_step(idle);
    chk("seq u0 NXPCO", if0.NXPCO, 32'h0000_010C);
    chk("seq u0 PCO", if0.PCO, 32'h0000_0108);
    chk("seq u2 NXPCO wrap", if2.NXPCO, 32'h0000_0008);

    do_step(mk(0, 1, 0, 0, 0, 32'h0000_2001, 32'h0));
    do_step(mk(1, 1, 1, 1, 1, 32'h0000_5555, 32'h44));
    do_step(mk(1, 0, 0, 1, 0, 32'h0, 32'h0));
    chk("halt u0 NXPCO", if0.NXPCO, 32'h0000_2000);
    do_step(idle);
    chk("after halt u0 NXPCO", if0.NXPCO, 32'h0000_2004);

    do_step(mk(0, 1, 0, 0, 0, 32'h0000_2002, 32'h0000_0080));
    chk("misalign u0 NXPCO", if0.NXPCO, 32'h0000_0080);
    chk("misalign u0 pulse", 32'(if0.MISALIGN), 32'd1);
    chk("align2 u2 NXPCO", if2.NXPCO, 32'h0000_2002);
    do_step(idle);
    chk("misalign u0 one-shot", 32'(if0.MISALIGN), 32'd0);

    do_step(mk(0, 0, 0, 1, 0, 32'h0, 32'h0));
    chk("tsw u1 NXPCO", if1.NXPCO, 32'h0000_1000);
    do_step(idle);
    do_step(mk(0, 1, 1, 1, 0, 32'h0000_0700, 32'h0000_0300));
    chk("trap+sw u1 ETIDO", 32'(if1.ETIDO), 32'd1);
    chk("trap+sw u1 TIDO", 32'(if1.TIDO), 32'd0);
    do_step(mk(0, 0, 0, 1, 0, 32'h0, 32'h0));
    chk("back u1 NXPCO", if1.NXPCO, 32'h0000_0300);

    do_step(mk(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0));
    do_step(mk(0, 0, 0, 0, 1, 32'h0, 32'h0));
    do_step(mk(0, 0, 0, 0, 0, 32'h0, 32'h0));
    do_step(mk(0, 0, 0, 1, 1, 32'h0, 32'h0));
    drive(mk(1, 0, 0, 0, 0, 32'h0, 32'h0));
    async_reset("areset-halt");
    drive(idle);

    repeat (400) begin
      s = mk($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
             1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 59) == 0) begin
        drive(s);
        async_reset("areset-rand");
      end else begin
        do_step(s);
      end
    end

    @(negedge CLK);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_mt.md
Name: pc_mt

Overview:
- Parametrised successor to the single-thread program counter, used at the core fetch stage.
- Holds one next-PC register per hardware thread and one shared current-PC register.
- Supports round-robin thread switch, trap redirect with exception-PC capture, and jump-target misalignment detection.
- Supports optional 2-byte instruction alignment for compressed instructions.

Parameters:
- XLEN, 32, address width in bits.
- RESETPC, 32'h0000_0000, reset value of thread 0 next-PC and of PC (XLEN bits).
- RESETSTRIDE, 32'h0, thread t resets to RESETPC + t*RESETSTRIDE.
- NTHREADS, 2, hardware thread count: 1, 2 or 4.
- IALIGN, 4, instruction alignment in bytes: 4, or 2 (compressed enabled).
- TIDW, derived localparam = max(1, clog2(NTHREADS)).

Ports:
- CLK  in  1  clock, rising edge.
- XRESN  in  1  asynchronous active-low reset.
- HLT  in  1  pipeline halt; freezes all state.
- JREQ  in  1  jump/branch taken.
- JVAL  in  XLEN  jump target.
- TREQ  in  1  trap request.
- TVEC  in  XLEN  trap vector.
- ILEN2  in  1  current instruction is 16-bit; used only when IALIGN=2.
- TSW  in  1  switch to next thread after this cycle.
- PCO  out  XLEN  PC of instruction in execute (t+0).
- NXPCO  out  XLEN  fetch address (t+1) of active thread.
- TIDO  out  TIDW  active thread id.
- EPCO  out  XLEN  PC captured at last trap.
- ETIDO  out  TIDW  thread id captured at last trap.
- MISALIGN  out  1  one-cycle pulse: misaligned jump converted to trap.

Behaviour:
- Reset (XRESN=0, async):
  - NXPC[t] = RESETPC + t*RESETSTRIDE.
  - PC = RESETPC; TID = 0; EPC = 0; ETID = 0; MISALIGN = 0.
- Combinational outputs: NXPCO = NXPC[TID]; TIDO = TID. All other outputs are registered.
- Increment INC: 4 when IALIGN=4; when IALIGN=2, INC = 2 if ILEN2 else 4.
- Jump target: JVAL[0] is treated as 0.
  - Misaligned (MIS) when JREQ=1, IALIGN=4 and JVAL[1]=1.
  - IALIGN=2 never flags MIS.
- Each rising edge with HLT=0 (priority top-down):
  - TREQ or MIS: NXPC[TID] <= TVEC; EPC <= PC; ETID <= TID.
  - else JREQ: NXPC[TID] <= {JVAL[XLEN-1:1],1'b0}.
  - else: NXPC[TID] <= NXPC[TID] + INC, modulo 2^XLEN (wraps from all-ones region to 0, no flag).
  - Always: PC <= NXPC[TID] (old value).
  - MISALIGN <= MIS & ~TREQ.
  - TSW=1: TID <= (TID+1) mod NTHREADS. The next-PC update above still applies to the old TID.
- HLT=1: all registers hold, including MISALIGN. JREQ, TREQ, TSW and ILEN2 are ignored (upstream re-presents them).
- NTHREADS=1: TSW ignored and TID is constantly 0. Behaviour then equals the legacy single-thread PC plus trap/misalign.
- Non-active threads' NXPC never change except at reset.
- Simultaneous TREQ and JREQ: trap wins; MISALIGN stays 0.
- Simultaneous TREQ and TSW: trap is recorded for the old thread, then the switch occurs.
- Reset asserted mid-operation: immediate return to reset values irrespective of HLT.

Decomposition:
- Package pc_mt_pkg: IALIGN legal-value constants, TIDW function (clog2 with min 1), default RESETPC.
- One combinational sub-module, pc_next_sel: inputs cur NXPC, INC, JREQ, JVAL, TREQ, TVEC, IALIGN; outputs next value and MIS.
- Thread register array, PC, TID, EPC and ETID stay in pc_mt.

Test Plan:
- Reset/sequential (RESETPC=0x100, NTHREADS=1): release XRESN, 3 cycles idle -> NXPCO 0x104, 0x108, 0x10C; PCO lags by one cycle (0x100, 0x104, 0x108).
- Jump and halt: JREQ=1, JVAL=0x2001 -> next NXPCO=0x2000, PCO=previous NXPCO. Then HLT=1 for 2 cycles -> NXPCO/PCO unchanged. Release -> 0x2004.
- Misalign (IALIGN=4): JREQ=1, JVAL=0x2002, TVEC=0x80 with PC=0x40 -> NXPCO=0x80, EPCO=0x40, MISALIGN pulses 1 cycle. Same with IALIGN=2 -> NXPCO=0x2002, no pulse.
- Threads (NTHREADS=2, RESETSTRIDE=0x1000): run 2 cycles, pulse TSW -> TIDO=1, NXPCO=0x1000. Pulse TSW again -> TIDO=0, NXPCO=0x008.
- Trap+jump+switch same cycle on TID=1: TREQ=1, JREQ=1, TSW=1, TVEC=0x300 -> ETIDO=1, EPCO=PC, TIDO=0, MISALIGN=0. Later switch back -> NXPCO=0x300.
- Wrap/compressed (IALIGN=2, RESETPC=0xFFFF_FFFC): ILEN2=1 -> 0xFFFF_FFFE. Then ILEN2=0 -> 0x0000_0002. Async reset asserted mid-cycle -> outputs return to reset values before the next edge.
